// File: rtl/ct_uv_loader.sv
// Ciphertext u/v stream loader for the HQC decrypt block.
// Packs 32-bit words into RAM lines and serves two registered read ports.
module ct_uv_loader #(
    parameter string parameter_set = "hqc128",
    parameter int N = (parameter_set == "hqc256") ? 57637 :
                      (parameter_set == "hqc192") ? 35851 : 17669,
    parameter int N1N2 = (parameter_set == "hqc256") ? 57600 :
                         (parameter_set == "hqc192") ? 35840 : 17664,
    parameter int RAMWIDTH = 128,
    parameter int IN_WIDTH = 32,
    parameter int ADDR_W = $clog2(2 * ((N + RAMWIDTH - 1) / RAMWIDTH))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic                load_done,
    output logic                loaded,
    input  logic [ADDR_W-1:0]   uv_addr_0,
    input  logic [ADDR_W-1:0]   uv_addr_1,
    input  logic                sel_uv,
    output logic [RAMWIDTH-1:0] uv_0,
    output logic [RAMWIDTH-1:0] uv_1
);

    localparam int LANES    = RAMWIDTH / IN_WIDTH;
    localparam int U_WORDS  = (N + IN_WIDTH - 1) / IN_WIDTH;
    localparam int V_WORDS  = (N1N2 + IN_WIDTH - 1) / IN_WIDTH;
    localparam int U_DEPTH  = (N + RAMWIDTH - 1) / RAMWIDTH;
    localparam int V_DEPTH  = (N1N2 + RAMWIDTH - 1) / RAMWIDTH;
    localparam int WC_W     = $clog2(U_WORDS + 1);
    localparam int LG_LANES = $clog2(LANES);
    localparam int LINE_W   = WC_W - LG_LANES;
    localparam int U_AW     = $clog2(U_DEPTH);
    localparam int V_AW     = $clog2(V_DEPTH);
    localparam int U_TAIL   = N % IN_WIDTH;

    localparam logic [IN_WIDTH-1:0] U_MASK =
        (U_TAIL == 0) ? {IN_WIDTH{1'b1}} :
        IN_WIDTH'((64'd1 << U_TAIL) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_U,
        LOAD_V,
        DONE,
        READY
    } state_t;

    state_t state_q, state_d;

    logic [WC_W-1:0]     word_cnt;
    logic [LG_LANES-1:0] lane_cnt;
    logic [LINE_W-1:0]   line_idx;
    logic [RAMWIDTH-1:0] pack;
    logic                wr_pend;
    logic                wr_last;
    logic [LINE_W-1:0]   wr_line;
    logic                start_load;
    logic                xfer;
    logic                in_u;
    logic                is_last;
    logic [IN_WIDTH-1:0] word_in;
    logic [RAMWIDTH-1:0] rd_0, rd_1;

    logic [RAMWIDTH-1:0] u_ram [U_DEPTH];
    logic [RAMWIDTH-1:0] v_ram [V_DEPTH];

    // Lane and line both fall out of the shared word counter.
    assign lane_cnt = word_cnt[LG_LANES-1:0];
    assign line_idx = word_cnt[WC_W-1:LG_LANES];
    assign in_u     = (state_q == LOAD_U);
    assign is_last  = in_u ? (word_cnt == WC_W'(U_WORDS - 1))
                           : (word_cnt == WC_W'(V_WORDS - 1));
    assign word_in  = (in_u && is_last) ? (din & U_MASK) : din;
    assign xfer     = din_valid && din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        din_ready  = 1'b0;
        load_done  = 1'b0;
        loaded     = 1'b0;
        start_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_U;
                    start_load = 1'b1;
                end
            end
            LOAD_U: begin
                din_ready = !wr_pend;
                if (wr_pend && wr_last) state_d = LOAD_V;
            end
            LOAD_V: begin
                din_ready = !wr_pend;
                if (wr_pend && wr_last) state_d = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                loaded    = 1'b1;
                state_d   = READY;
            end
            READY: begin
                loaded = 1'b1;
                if (start) begin
                    state_d    = LOAD_U;
                    start_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A filled line is written the cycle after its last word; input stalls then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            pack     <= '0;
            wr_pend  <= 1'b0;
            wr_last  <= 1'b0;
            wr_line  <= '0;
        end else if (start_load) begin
            word_cnt <= '0;
            pack     <= '0;
            wr_pend  <= 1'b0;
            wr_last  <= 1'b0;
        end else if (wr_pend) begin
            pack    <= '0;
            wr_pend <= 1'b0;
            wr_last <= 1'b0;
            if (wr_last) word_cnt <= '0;
        end else if (xfer) begin
            pack[int'(lane_cnt) * IN_WIDTH +: IN_WIDTH] <= word_in;
            wr_pend  <= (&lane_cnt) || is_last;
            wr_last  <= is_last;
            wr_line  <= line_idx;
            word_cnt <= word_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pend && state_q == LOAD_U) u_ram[wr_line] <= pack;
        if (wr_pend && state_q == LOAD_V) v_ram[wr_line] <= pack;
    end

    // Addresses past the polynomial read as zero padding.
    always_comb begin
        rd_0 = '0;
        rd_1 = '0;
        if (sel_uv) begin
            if (uv_addr_0 < ADDR_W'(V_DEPTH)) rd_0 = v_ram[uv_addr_0[V_AW-1:0]];
            if (uv_addr_1 < ADDR_W'(V_DEPTH)) rd_1 = v_ram[uv_addr_1[V_AW-1:0]];
        end else begin
            if (uv_addr_0 < ADDR_W'(U_DEPTH)) rd_0 = u_ram[uv_addr_0[U_AW-1:0]];
            if (uv_addr_1 < ADDR_W'(U_DEPTH)) rd_1 = u_ram[uv_addr_1[U_AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uv_0 <= '0;
            uv_1 <= '0;
        end else begin
            uv_0 <= rd_0;
            uv_1 <= rd_1;
        end
    end

endmodule

// File: tb/tb_ct_uv_loader.sv
// Directed bench for ct_uv_loader (hqc128): loads, tail mask, readback,
// padding reads, gapped load with stray start, and reset mid-load.
module tb_ct_uv_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  din;
    logic         din_valid;
    logic         din_ready;
    logic         load_done;
    logic         loaded;
    logic [8:0]   uv_addr_0;
    logic [8:0]   uv_addr_1;
    logic         sel_uv;
    logic [127:0] uv_0;
    logic [127:0] uv_1;

    int errors = 0;
    int checks = 0;

    int  xf, dn, se, ab_n, ab_c;
    bit  to;

    ct_uv_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .load_done (load_done),
        .loaded    (loaded),
        .uv_addr_0 (uv_addr_0),
        .uv_addr_1 (uv_addr_1),
        .sel_uv    (sel_uv),
        .uv_0      (uv_0),
        .uv_1      (uv_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wv(input int k, input logic [31:0] u_last);
        if (k == 552) return u_last;
        if (k < 553) return 32'(k);
        return 32'h8000_0000 | 32'(k - 553);
    endfunction

    function automatic logic [127:0] exp_u(input int l, input logic [31:0] u_last);
        logic [127:0] line;
        logic [31:0]  w;
        line = '0;
        for (int j = 0; j < 4; j++) begin
            if (4 * l + j < 553) begin
                w = wv(4 * l + j, u_last);
                if (4 * l + j == 552) w = w & 32'h0000_001F;
                line[32 * j +: 32] = w;
            end
        end
        return line;
    endfunction

    function automatic logic [127:0] exp_v(input int l);
        logic [127:0] line;
        for (int j = 0; j < 4; j++)
            line[32 * j +: 32] = 32'h8000_0000 | 32'(4 * l + j);
        return line;
    endfunction

    task automatic rd(input logic s, input int a0, input int a1);
        sel_uv    = s;
        uv_addr_0 = 9'(a0);
        uv_addr_1 = 9'(a1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input bit gaps, input bit inj,
                            input logic [31:0] u_last,
                            output int xfers, output int dones,
                            output int stall_err, output bit timeout);
        int   k = 0;
        int   cyc = 0;
        int   tail = 0;
        bit   exp_stall = 0;
        bit   exp_resume = 0;
        bit   last_line = 0;
        bit   injected = 0;
        logic r;
        xfers = 0;
        dones = 0;
        stall_err = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("loaded_drop", {127'd0, loaded}, 128'd0);
        while (tail < 4 && cyc < 5000) begin
            r = din_ready;
            if (load_done === 1'b1) dones++;
            if (exp_stall) begin
                if (r !== 1'b0) stall_err++;
                exp_stall  = 0;
                exp_resume = !last_line;
            end else if (exp_resume) begin
                if (r !== 1'b1) stall_err++;
                exp_resume = 0;
            end
            start = inj && !injected && k == 800;
            if (start) injected = 1;
            din_valid = (k < 1105) && (!gaps || $urandom_range(0, 1) == 1);
            din = (k < 1105) ? wv(k, u_last) : 32'd0;
            if (r === 1'b1 && din_valid) begin
                xfers++;
                if (k < 553) exp_stall = (k % 4 == 3) || (k == 552);
                else         exp_stall = ((k - 553) % 4 == 3);
                last_line = (k == 1104);
                k++;
            end
            if (k == 1105 && dones > 0) tail++;
            @(posedge clk);
            #1;
            cyc++;
        end
        start     = 1'b0;
        din_valid = 1'b0;
        timeout   = (cyc >= 5000);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sel_uv    = 1'b0;
        uv_addr_0 = '0;
        uv_addr_1 = '0;
        #1;
        chk("rst_din_ready", {127'd0, din_ready}, 128'd0);
        chk("rst_load_done", {127'd0, load_done}, 128'd0);
        chk("rst_loaded", {127'd0, loaded}, 128'd0);
        chk("rst_uv_0", uv_0, 128'd0);
        chk("rst_uv_1", uv_1, 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ready", {127'd0, din_ready}, 128'd0);

        // Gap-free load, last u word = 552
        run_load(0, 0, 32'd552, xf, dn, se, to);
        chk("l1_timeout", {127'd0, to}, 128'd0);
        chk("l1_xfers", 128'(xf), 128'd1105);
        chk("l1_dones", 128'(dn), 128'd1);
        chk("l1_stalls", 128'(se), 128'd0);
        chk("l1_loaded", {127'd0, loaded}, 128'd1);

        rd(0, 138, 0);
        chk("l1_u138", uv_0, 128'h0000_0008);
        chk("l1_u0", uv_1, 128'h0000_0003_0000_0002_0000_0001_0000_0000);
        rd(1, 0, 137);
        chk("l1_v0", uv_0, 128'h8000_0003_8000_0002_8000_0001_8000_0000);
        chk("l1_v137", uv_1, 128'h8000_0227_8000_0226_8000_0225_8000_0224);
        rd(0, 139, 139);
        chk("oor_u139_p0", uv_0, 128'd0);
        chk("oor_u139_p1", uv_1, 128'd0);
        rd(1, 138, 277);
        chk("oor_v138", uv_0, 128'd0);
        chk("oor_v277", uv_1, 128'd0);
        rd(1, 5, 5);
        chk("same_addr_p0", uv_0, exp_v(5));
        chk("same_addr_p1", uv_1, exp_v(5));
        rd(0, 77, 1);
        chk("l1_u77", uv_0, exp_u(77, 32'd552));
        chk("l1_u1", uv_1, exp_u(1, 32'd552));

        // Reload from READY with gaps and a stray start mid-v
        run_load(1, 1, 32'hFFFF_FFFF, xf, dn, se, to);
        chk("l2_timeout", {127'd0, to}, 128'd0);
        chk("l2_xfers", 128'(xf), 128'd1105);
        chk("l2_dones", 128'(dn), 128'd1);
        chk("l2_stalls", 128'(se), 128'd0);
        chk("l2_loaded", {127'd0, loaded}, 128'd1);
        rd(0, 138, 50);
        chk("l2_tail_mask", uv_0, 128'h0000_001F);
        chk("l2_u50", uv_1, exp_u(50, 32'hFFFF_FFFF));
        rd(1, 100, 137);
        chk("l2_v100", uv_0, exp_v(100));
        chk("l2_v137", uv_1, exp_v(137));

        // Reset after 300 u words, then a fresh load
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        ab_n      = 0;
        ab_c      = 0;
        din_valid = 1'b1;
        while (ab_n < 300 && ab_c < 1000) begin
            din = wv(ab_n, 32'd552);
            if (din_ready === 1'b1) ab_n++;
            @(posedge clk);
            #1;
            ab_c++;
        end
        din_valid = 1'b0;
        chk("ab_words", 128'(ab_n), 128'd300);
        rst = 1'b1;
        #1;
        chk("ab_loaded", {127'd0, loaded}, 128'd0);
        chk("ab_ready", {127'd0, din_ready}, 128'd0);
        chk("ab_done", {127'd0, load_done}, 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_load(0, 0, 32'd552, xf, dn, se, to);
        chk("l3_timeout", {127'd0, to}, 128'd0);
        chk("l3_xfers", 128'(xf), 128'd1105);
        chk("l3_dones", 128'(dn), 128'd1);
        chk("l3_stalls", 128'(se), 128'd0);
        chk("l3_loaded", {127'd0, loaded}, 128'd1);
        rd(0, 138, 74);
        chk("l3_u138", uv_0, 128'h0000_0008);
        chk("l3_u74", uv_1, exp_u(74, 32'd552));
        rd(1, 0, 137);
        chk("l3_v0", uv_0, exp_v(0));
        chk("l3_v137", uv_1, exp_v(137));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ct_uv_loader.md
Name: ct_uv_loader

Overview:
- Upstream stage of the decrypt block in the HQC decapsulation path.
- Accepts ciphertext polynomials u then v as a 32-bit word stream and packs them into RAMWIDTH-bit lines, masking the padding bits of u beyond N.
- Stores u and v in two internal RAMs.
- Serves the decrypt block's dual read ports (uv_addr_0/1, sel_uv) with registered 1-cycle-latency data.

Parameters:
- parameter_set, "hqc128", selects N / N1N2 ("hqc128"/"hqc192"/"hqc256").
- N, 17669 (hqc128) / 35851 / 57637, length of u in bits.
- N1N2, 17664 / 35840 / 57600, length of v in bits.
- RAMWIDTH, 128, RAM line width; must be a multiple of IN_WIDTH.
- IN_WIDTH, 32, stream word width.
- LANES, RAMWIDTH/IN_WIDTH, words per line.
- U_WORDS, ceil(N/IN_WIDTH), u stream words (553 for hqc128).
- V_WORDS, ceil(N1N2/IN_WIDTH), v stream words (552).
- U_DEPTH, ceil(N/RAMWIDTH), u RAM lines (139).
- V_DEPTH, ceil(N1N2/RAMWIDTH), v RAM lines (138).
- ADDR_W, `CLOG2(X) with X as in decrypt, read address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  1-cycle pulse; begins a load.
- din  in  IN_WIDTH  stream word; first u word first, little-endian bit order.
- din_valid  in  1  din qualifier.
- din_ready  out  1  block accepts din this cycle.
- load_done  out  1  1-cycle pulse after the last v word is written.
- loaded  out  1  level: RAM contents valid.
- uv_addr_0  in  ADDR_W  read address, port 0.
- uv_addr_1  in  ADDR_W  read address, port 1.
- sel_uv  in  1  0 = read u RAM, 1 = read v RAM (both ports).
- uv_0  out  RAMWIDTH  read data, port 0.
- uv_1  out  RAMWIDTH  read data, port 1.

Behaviour:
- Reset (async, rst=1): state IDLE, all counters 0, pack register 0. Outputs: din_ready=0, load_done=0, loaded=0, uv_0=0, uv_1=0. RAM contents undefined; loaded=0 marks them invalid.
- State machine: IDLE -> LOAD_U -> LOAD_V -> DONE -> READY.
  - IDLE: din_ready=0. On start, go to LOAD_U, clear word counter, lane counter and pack register.
  - LOAD_U: din_ready=1. Transfer occurs when din_valid & din_ready. Each transfer writes din into lane[lane_cnt] of the pack register; line index = word_cnt / LANES.
  - When lane LANES-1 is filled, or the word is word U_WORDS-1, write the pack register to u_ram[line] in the next cycle and clear the pack register. Unfilled lanes are zero.
  - Word U_WORDS-1 is ANDed with a mask keeping bits [(N mod IN_WIDTH)-1:0] (all bits if N mod IN_WIDTH = 0). hqc128: bits [4:0] kept, lane 0 of line 138.
  - After that final u write, go to LOAD_V; v starts at lane 0 of line 0.
  - LOAD_V: same packing into v_ram. After word V_WORDS-1 is written, go to DONE. No masking is needed for v: N1N2 is a multiple of IN_WIDTH for all sets.
  - DONE: one cycle, load_done=1, loaded=1, then READY.
  - READY: din_ready=0. loaded holds 1.
- start in READY: reload. loaded drops to 0 the next cycle; go to LOAD_U.
- start during LOAD_U, LOAD_V or DONE: ignored.
- Back-pressure: din_ready is held 0 for the single cycle in which a full line is written. This allows a one-line write port per RAM with no skid buffer. Sustained throughput is LANES words per LANES+1 cycles.
- Read path:
  - Registered, 1-cycle latency: uv_0 at cycle t+1 = RAM[sel_uv][uv_addr_0 at cycle t]; uv_1 likewise.
  - Address >= U_DEPTH (sel_uv=0) or >= V_DEPTH (sel_uv=1) returns all zeros. Required by the multiplier's padded address space up to X.
  - Reads are permitted in any state. Data returned while loaded=0 is don't-care, except out-of-range addresses, which always return 0.
  - Simultaneous equal addresses on both ports return identical data.
- Width rules: the word counter is `CLOG2(U_WORDS+1) bits and is shared by u and v. Line index = counter >> log2(LANES); LANES must be a power of 2.
- Reset mid-load: immediate abort to IDLE with loaded=0. No partial load_done.

Test Plan:
- hqc128 full load: start, 553 u words with value i for word i, then 552 v words with value 0x8000_0000|i, din_valid held 1.
  - -> load_done exactly once; loaded=1.
  - -> 1105 transfers in total.
  - -> din_ready low for exactly one cycle after every 4th word.
- Tail mask: last u word 0xFFFF_FFFF, then sel_uv=0, uv_addr_0=138.
  - -> uv_0 = 0x...0000_001F: lane 0 = 0x1F, lanes 1-3 = 0.
- Readback: sel_uv=1, uv_addr_0=0, uv_addr_1=137 in the same cycle.
  - -> next cycle uv_0 = {v3,v2,v1,v0}, uv_1 = {v551,v550,v549,v548}.
- Out of range: sel_uv=0, addr 139; sel_uv=1, addr 138 and 277.
  - -> uv_0/uv_1 = 0.
- Random din_valid gaps (50% duty) plus a start pulse injected mid-LOAD_V.
  - -> RAM contents identical to the gap-free run; start ignored; one load_done.
- rst asserted after 300 u words, then a fresh full load.
  - -> loaded=0 and din_ready=0 immediately.
  - -> second load completes correctly with a single load_done.
